// File: rtl/ticket_pkg.sv
// Shared types for the ticket-sale change path.
// Coin codes, coin values and dispenser state encoding.
package ticket_pkg;

  localparam int AMOUNT_W_DEF = 8;

  typedef enum logic [1:0] {
    COIN_1  = 2'd0,
    COIN_5  = 2'd1,
    COIN_10 = 2'd2,
    COIN_20 = 2'd3
  } coin_e;

  localparam int VAL_1  = 1;
  localparam int VAL_5  = 5;
  localparam int VAL_10 = 10;
  localparam int VAL_20 = 20;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPENSE = 2'd1,
    S_DONE     = 2'd2
  } state_e;

endpackage

// File: rtl/change_dispenser_if.sv
// Control-side and hopper-side signals of the change dispenser.
// slave = dispenser, master = control block / hopper side.
interface change_dispenser_if #(
  parameter int AMOUNT_W = 8
);

  logic [AMOUNT_W-1:0] moneyReturn;
  logic                moneyFinish;
  logic                coinReady;
  logic                coinValid;
  logic [1:0]          coinOut;
  logic [AMOUNT_W-1:0] remaining;
  logic                busy;
  logic                changeDone;
  logic                changeFault;

  modport master (
    output moneyReturn,
    output moneyFinish,
    output coinReady,
    input  coinValid,
    input  coinOut,
    input  remaining,
    input  busy,
    input  changeDone,
    input  changeFault
  );

  modport slave (
    input  moneyReturn,
    input  moneyFinish,
    input  coinReady,
    output coinValid,
    output coinOut,
    output remaining,
    output busy,
    output changeDone,
    output changeFault
  );

endinterface

// File: rtl/change_dispenser_coin_select.sv
// Greedy coin chooser: largest coin not exceeding amount.
// Amount of zero maps to the 1-yuan code (never dispensed).
module coin_select
  import ticket_pkg::*;
#(
  parameter int AMOUNT_W = AMOUNT_W_DEF
) (
  input  logic [AMOUNT_W-1:0] amount_i,
  output coin_e               code_o,
  output logic [AMOUNT_W-1:0] value_o
);

  logic ge20;
  logic ge10;
  logic ge5;

  assign ge20 = amount_i >= AMOUNT_W'(VAL_20);
  assign ge10 = amount_i >= AMOUNT_W'(VAL_10);
  assign ge5  = amount_i >= AMOUNT_W'(VAL_5);

  // Mutually exclusive ranges pick one coin.
  always_comb begin
    code_o  = COIN_1;
    value_o = AMOUNT_W'(VAL_1);
    unique case (1'b1)
      ge20: begin
        code_o  = COIN_20;
        value_o = AMOUNT_W'(VAL_20);
      end
      ge10 & ~ge20: begin
        code_o  = COIN_10;
        value_o = AMOUNT_W'(VAL_10);
      end
      ge5 & ~ge10: begin
        code_o  = COIN_5;
        value_o = AMOUNT_W'(VAL_5);
      end
      default: begin
        code_o  = COIN_1;
        value_o = AMOUNT_W'(VAL_1);
      end
    endcase
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out latched change one coin per handshake.
// HOPPER_TIMEOUT_EN adds a hopper stall abort with changeFault.
module change_dispenser
  import ticket_pkg::*;
#(
  parameter int AMOUNT_W = AMOUNT_W_DEF,
  parameter int TIMEOUT  = 255
) (
  input  logic          clk,
  input  logic          rst,
  change_dispenser_if.slave bus
);

  state_e              state_q;
  logic [AMOUNT_W-1:0] remaining_q;
  logic                finish_prev_q;
  logic                valid_q;
  logic                busy_q;
  logic                done_q;

  coin_e               sel_code;
  logic [AMOUNT_W-1:0] sel_val;
  logic [AMOUNT_W-1:0] rem_d;
  logic                start;

  coin_select #(
    .AMOUNT_W (AMOUNT_W)
  ) u_sel (
    .amount_i (remaining_q),
    .code_o   (sel_code),
    .value_o  (sel_val)
  );

  assign rem_d = remaining_q - sel_val;
  assign start = bus.moneyFinish & ~finish_prev_q;

`ifdef HOPPER_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] wait_q;
  logic          fault_q;

  assign bus.changeFault = fault_q;
`else
  logic unused_timeout;

  assign unused_timeout  = (TIMEOUT != 0);
  assign bus.changeFault = 1'b0;
`endif

  // Transaction FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      remaining_q   <= '0;
      finish_prev_q <= 1'b1;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef HOPPER_TIMEOUT_EN
      wait_q        <= '0;
      fault_q       <= 1'b0;
`endif
    end else begin
      finish_prev_q <= bus.moneyFinish;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            remaining_q <= bus.moneyReturn;
            busy_q      <= 1'b1;
            if (bus.moneyReturn != '0) begin
              state_q <= S_DISPENSE;
              valid_q <= 1'b1;
`ifdef HOPPER_TIMEOUT_EN
              wait_q  <= '0;
`endif
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_DISPENSE: begin
          if (bus.coinReady) begin
            remaining_q <= rem_d;
`ifdef HOPPER_TIMEOUT_EN
            wait_q      <= '0;
`endif
            if (rem_d == '0) begin
              state_q <= S_DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
`ifdef HOPPER_TIMEOUT_EN
          else if (wait_q == WAIT_LAST) begin
            state_q <= S_DONE;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            fault_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
`endif
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
`ifdef HOPPER_TIMEOUT_EN
          fault_q <= 1'b0;
`endif
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.coinValid  = valid_q;
  assign bus.coinOut    = sel_code;
  assign bus.remaining  = remaining_q;
  assign bus.busy       = busy_q;
  assign bus.changeDone = done_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: vector table, corner sequences,
// and random transactions against a greedy payout model.
module tb_change_dispenser;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  change_dispenser_if #(.AMOUNT_W(8)) bus ();

  change_dispenser #(
    .AMOUNT_W (8),
    .TIMEOUT  (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  typedef struct {
    int amt;
    int coins;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int coin_val(input int c);
    case (c)
      3: return 20;
      2: return 10;
      1: return 5;
      default: return 1;
    endcase
  endfunction

  // Expected payout as coin counts by integer division.
  function automatic void plan(input int amt);
    int r;
    int n;
    exp_q.delete();
    r = amt;
    n = r / 20; r = r % 20;
    repeat (n) exp_q.push_back(3);
    n = r / 10; r = r % 10;
    repeat (n) exp_q.push_back(2);
    n = r / 5;  r = r % 5;
    repeat (n) exp_q.push_back(1);
    repeat (r) exp_q.push_back(0);
  endfunction

  function automatic int owed();
    int s = 0;
    foreach (exp_q[i]) s += coin_val(exp_q[i]);
    return s;
  endfunction

  task automatic start(input int amt);
    bus.moneyReturn = 8'(amt);
    bus.moneyFinish = 1'b1;
    tick();
    bus.moneyFinish = 1'b0;
  endtask

  task automatic run_txn(input int amt, input int pct,
                         input bit noise, output int ncoins);
    bit rdy;
    bit fin;
    plan(amt);
    ncoins = 0;
    fin = 1'b0;
    bus.coinReady = ($urandom_range(0, 99) < pct);
    start(amt);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (exp_q.size() > 0) begin
        chk("valid", bus.coinValid, 1);
        chk("coinOut", bus.coinOut, exp_q[0]);
        chk("remaining", bus.remaining, owed());
        chk("busy", bus.busy, 1);
        chk("done_early", bus.changeDone, 0);
        rdy = ($urandom_range(0, 99) < pct);
        bus.coinReady = rdy;
        if (noise) begin
          bus.moneyFinish = 1'($urandom_range(0, 1));
          bus.moneyReturn = 8'($urandom_range(0, 255));
        end
        tick();
        if (rdy) begin
          void'(exp_q.pop_front());
          ncoins++;
        end
      end else begin
        bus.moneyFinish = 1'b0;
        chk("done", bus.changeDone, 1);
        chk("valid_done", bus.coinValid, 0);
        chk("fault", bus.changeFault, 0);
        chk("busy_done", bus.busy, 1);
        chk("rem_done", bus.remaining, 0);
        tick();
        chk("done_off", bus.changeDone, 0);
        chk("busy_off", bus.busy, 0);
        fin = 1'b1;
        break;
      end
    end
    if (!fin) chk("txn_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int ec[4];
    int er[4];

    tbl[0] = '{36, 4};
    tbl[1] = '{0, 0};
    tbl[2] = '{1, 1};
    tbl[3] = '{4, 4};
    tbl[4] = '{5, 1};
    tbl[5] = '{19, 6};
    tbl[6] = '{20, 1};
    tbl[7] = '{25, 2};
    tbl[8] = '{99, 10};
    tbl[9] = '{255, 14};
    ec = '{3, 2, 1, 0};
    er = '{36, 16, 6, 1};

    rst = 1'b0;
    bus.moneyReturn = '0;
    bus.moneyFinish = 1'b0;
    bus.coinReady = 1'b0;
    #12;
    chk("rst_valid", bus.coinValid, 0);
    chk("rst_out", bus.coinOut, 0);
    chk("rst_rem", bus.remaining, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.changeDone, 0);
    chk("rst_fault", bus.changeFault, 0);
    rst = 1'b1;
    tick();

    // 36: exact coin and remaining trace
    bus.coinReady = 1'b1;
    start(36);
    for (int i = 0; i < 4; i++) begin
      chk("t36_valid", bus.coinValid, 1);
      chk("t36_code", bus.coinOut, ec[i]);
      chk("t36_rem", bus.remaining, er[i]);
      tick();
    end
    chk("t36_rem0", bus.remaining, 0);
    chk("t36_done", bus.changeDone, 1);
    tick();
    chk("t36_busy", bus.busy, 0);
    chk("t36_done_off", bus.changeDone, 0);

    // zero amount: done in first cycle, no coin
    start(0);
    chk("z_done", bus.changeDone, 1);
    chk("z_valid", bus.coinValid, 0);
    chk("z_fault", bus.changeFault, 0);
    tick();
    chk("z_done_off", bus.changeDone, 0);
    chk("z_busy", bus.busy, 0);

    // 25 with a three-cycle hopper stall
    bus.coinReady = 1'b0;
    start(25);
    for (int i = 0; i < 3; i++) begin
      chk("st_valid", bus.coinValid, 1);
      chk("st_code", bus.coinOut, 3);
      chk("st_rem", bus.remaining, 25);
      tick();
    end
    bus.coinReady = 1'b1;
    chk("st_code_go", bus.coinOut, 3);
    tick();
    chk("st_rem5", bus.remaining, 5);
    chk("st_code5", bus.coinOut, 1);
    tick();
    chk("st_rem0", bus.remaining, 0);
    chk("st_done", bus.changeDone, 1);
    tick();

    // vector table, hopper always ready
    foreach (tbl[i]) begin
      run_txn(tbl[i].amt, 100, 1'b0, n);
      chk("tbl_coins", n, tbl[i].coins);
    end

    // reset mid-dispense with moneyFinish held high
    bus.coinReady = 1'b1;
    start(36);
    tick();
    chk("mr_rem16", bus.remaining, 16);
    bus.moneyFinish = 1'b1;
    rst = 1'b0;
    #2;
    chk("mr_valid", bus.coinValid, 0);
    chk("mr_out", bus.coinOut, 0);
    chk("mr_rem", bus.remaining, 0);
    chk("mr_busy", bus.busy, 0);
    chk("mr_done", bus.changeDone, 0);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_no_restart", {bus.busy, bus.coinValid}, 0);
    end
    bus.moneyFinish = 1'b0;
    tick();
    run_txn(5, 100, 1'b0, n);
    chk("mr_restart", n, 1);

`ifdef HOPPER_TIMEOUT_EN
    bus.coinReady = 1'b0;
    start(20);
    for (int i = 0; i < 8; i++) begin
      chk("to_valid", bus.coinValid, 1);
      chk("to_done_early", bus.changeDone, 0);
      chk("to_rem", bus.remaining, 20);
      tick();
    end
    chk("to_done", bus.changeDone, 1);
    chk("to_fault", bus.changeFault, 1);
    chk("to_rem_kept", bus.remaining, 20);
    chk("to_valid_off", bus.coinValid, 0);
    tick();
    chk("to_idle", {bus.busy, bus.changeDone, bus.changeFault}, 0);
    bus.coinReady = 1'b1;
`else
    bus.coinReady = 1'b0;
    start(20);
    for (int i = 0; i < 12; i++) begin
      chk("nt_valid", bus.coinValid, 1);
      chk("nt_fault", bus.changeFault, 0);
      chk("nt_done", bus.changeDone, 0);
      tick();
    end
    bus.coinReady = 1'b1;
    tick();
    chk("nt_finish", bus.changeDone, 1);
    chk("nt_rem", bus.remaining, 0);
    tick();
`endif

    // random transactions, stalls and ignored starts
    for (int t = 0; t < 40; t++) begin
      int amt;
      int pct;
      amt = $urandom_range(0, 255);
      pct = $urandom_range(30, 100);
      run_txn(amt, pct, 1'b1, n);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Change-dispensing stage that sits directly downstream of the ticket-sale `control` block. It consumes `control`'s `moneyReturn` amount and `moneyFinish` indication. It then drives the coin hopper one coin per handshake, choosing denominations greedily (20, 10, 5, 1 yuan) until the latched change amount reaches zero. Finally it pulses a completion flag back to the front panel.

## Interface
Parameters:
- AMOUNT_W, 8, width of change amount (matches `moneyReturn`)
- TIMEOUT, 255, hopper wait limit in cycles (used only with HOPPER_TIMEOUT_EN)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset; asynchronous and active-low
- moneyReturn  input  AMOUNT_W  change amount from `control`
- moneyFinish  input  1  change-valid level from `control`
- coinReady  input  1  hopper accepts the presented coin
- coinValid  output  1  coin request presented to hopper
- coinOut  output  2  denomination code: 0=1, 1=5, 2=10, 3=20
- remaining  output  AMOUNT_W  change still owed
- busy  output  1  high while a transaction is in progress
- changeDone  output  1  one-cycle completion pulse
- changeFault  output  1  qualifies changeDone: hopper timeout abort

## Operation
- States:
  - IDLE: wait for start.
  - DISPENSE: present coins until remaining is zero.
  - DONE: pulse completion, then return to IDLE.
- Start condition: rising edge of moneyFinish, detected with a registered copy `finishPrev`.
  - `finishPrev` resets to 1, so a level already high through reset does not trigger.
  - A level held high triggers only once.
- IDLE with start:
  - remaining <= moneyReturn.
  - Next state is DISPENSE if moneyReturn != 0, else DONE.
- DISPENSE:
  - coinValid=1.
  - coinOut = largest denomination <= remaining; combinational from the registered remaining.
  - On coinValid && coinReady: remaining <= remaining - value(coinOut).
  - If the new remaining is 0, go to DONE.
- DONE: changeDone=1 for exactly one cycle, then IDLE.
- busy=1 in DISPENSE and DONE.
- Starts and moneyReturn changes while busy are ignored, not queued.
- Arithmetic:
  - Unsigned AMOUNT_W subtraction.
  - Greedy selection guarantees no underflow.
  - 255 dispenses as 12×20, 1×10, 1×5 (14 coins).

## Timing
- Reset values:
  - State IDLE.
  - remaining=0, coinValid=0, coinOut=0, busy=0, changeDone=0, changeFault=0.
  - `finishPrev`=1.
- Latency:
  - Start sampled at edge N; first coinValid is visible after edge N (cycle N+1).
  - With coinReady held high, one coin per cycle.
  - changeDone occurs in the cycle after the final handshake.
  - Zero amount: changeDone in cycle N+1, no coinValid.
- Handshake: coinValid and coinOut stay stable until coinReady. coinReady while coinValid=0 is ignored.
- Reset mid-dispense: all outputs return to reset values immediately. The partial transaction is abandoned.

## Configuration
- Macro HOPPER_TIMEOUT_EN.
- Defined:
  - A wait counter clears on every handshake and on DISPENSE entry.
  - It increments each DISPENSE cycle with coinValid && !coinReady.
  - On reaching TIMEOUT, go to DONE with changeFault=1 for that pulse; remaining holds the undelivered amount.
- Undefined:
  - No counter; DISPENSE waits indefinitely.
  - changeFault is constant 0.
  - TIMEOUT is unused.

## Structure
- Shared package `ticket_pkg`:
  - Denomination codes and values (COIN_1/5/10/20).
  - State enum.
  - AMOUNT_W default.
- One sub-module, `coin_select`: combinational greedy chooser mapping remaining to coinOut and coin value.

## Test plan
- moneyReturn=36, coinReady=1, moneyFinish 0→1:
  - coinOut 3,2,1,0 on consecutive cycles.
  - remaining steps 16,6,1,0.
  - changeDone pulse on the next cycle.
  - busy drops after it.
- moneyReturn=0, moneyFinish edge: no coinValid; changeDone pulses in cycle N+1; changeFault=0.
- moneyReturn=25, coinReady low 3 cycles then high:
  - coinValid=1 and coinOut=3 held stable, remaining=25 throughout the stall.
  - Then remaining 5 → 0.
- moneyReturn=255, coinReady=1:
  - Exactly 14 handshakes: twelve code 3, then code 2, then code 1.
  - remaining ends at 0.
- Reset mid-dispense at remaining=16:
  - Outputs go to reset values immediately.
  - moneyFinish held high across reset does not restart; the next 0→1 edge does.
- HOPPER_TIMEOUT_EN, TIMEOUT=8, amount 20, coinReady stuck 0:
  - After 8 stall cycles, changeDone and changeFault pulse together.
  - remaining=20.
  - State returns to IDLE.
